// File: rtl/pixel_plotter_pkg.sv
// Shared types for the pixel plotter: FSM states, skid FIFO entry layout and a saturating counter helper.
// With PIXEL_PLOTTER_BBOX_EN defined, FIFO entries also carry the unclipped x/y for bounding-box tracking.
package pixel_plotter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRAW,
    DRAIN,
    DONE
  } state_e;

  // Must be at least the ADDR_W used by any pixel_plotter instance.
  localparam int ENTRY_ADDR_W = 12;

  typedef struct packed {
`ifdef PIXEL_PLOTTER_BBOX_EN
    logic signed [31:0] x;
    logic signed [31:0] y;
`endif
    logic [ENTRY_ADDR_W-1:0] addr;
  } fifo_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/plotter_fifo.sv
// Small first-word-fall-through synchronous FIFO; a push into a full FIFO is taken only when
// a pop happens in the same cycle. clear_i empties it and wins over push/pop.
module plotter_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pixel_plotter.sv
// Turns a signed (x, y) coordinate stream into clipped framebuffer writes, with a clear pass per frame.
// Optional macro PIXEL_PLOTTER_BBOX_EN adds bounding-box outputs over the written pixels.
module pixel_plotter
  import pixel_plotter_pkg::*;
#(
  parameter int FB_WIDTH   = 64,
  parameter int FB_HEIGHT  = 48,
  parameter int ADDR_W     = 12,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               _clock,
  input  logic               _reset_n,
  input  logic               _start,
  input  logic [COLOR_W-1:0] color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               _in_valid,
  input  logic signed [31:0] _in0,
  input  logic signed [31:0] _in1,
  input  logic               _in_done,
  output logic               _in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic [31:0]        pixel_count,
  output logic [31:0]        clip_count,
  output logic               _done
`ifdef PIXEL_PLOTTER_BBOX_EN
  ,
  output logic signed [31:0] bbox_xmin,
  output logic signed [31:0] bbox_xmax,
  output logic signed [31:0] bbox_ymin,
  output logic signed [31:0] bbox_ymax
`endif
);

  localparam int          N_PIX     = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
  localparam int          EW        = $bits(fifo_entry_t);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  clr_q, clr_d;
  logic [COLOR_W-1:0] color_q, color_d, bg_q, bg_d;
  logic [31:0]        pix_cnt_q, pix_cnt_d, clip_cnt_q, clip_cnt_d;

  fifo_entry_t        push_entry, head_entry;
  logic [EW-1:0]      head_vec;
  logic               fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  logic               in_bounds;

  assign in_bounds = (_in0 >= 32'sd0) && (_in0 < 32'(FB_WIDTH)) &&
                     (_in1 >= 32'sd0) && (_in1 < 32'(FB_HEIGHT));

  // Address is formed at accept time so the write side only forwards a stored value.
  always_comb begin
    push_entry      = '0;
    push_entry.addr = ENTRY_ADDR_W'(_in1 * 32'(FB_WIDTH) + _in0);
`ifdef PIXEL_PLOTTER_BBOX_EN
    push_entry.x    = _in0;
    push_entry.y    = _in1;
`endif
  end

  assign head_entry = fifo_entry_t'(head_vec);

  plotter_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (_clock),
    .rst_ni  (_reset_n),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_vec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef PIXEL_PLOTTER_BBOX_EN
  logic signed [31:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  assign bbox_xmin = xmin_q;
  assign bbox_xmax = xmax_q;
  assign bbox_ymin = ymin_q;
  assign bbox_ymax = ymax_q;
`endif

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    color_d    = color_q;
    bg_d       = bg_q;
    pix_cnt_d  = pix_cnt_q;
    clip_cnt_d = clip_cnt_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    _in_ready  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    _done      = 1'b0;
`ifdef PIXEL_PLOTTER_BBOX_EN
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;
`endif

    case (state_q)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_q;
        mem_data = bg_q;
        clr_d    = clr_q + ADDR_W'(1);
        if (clr_q == LAST_ADDR) state_d = DRAW;
      end
      DRAW: begin
        _in_ready = !fifo_full;
        if (_in_valid && !fifo_full) begin
          if (in_bounds) fifo_push  = 1'b1;
          else           clip_cnt_d = sat_inc(clip_cnt_q);
        end
        if (_in_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) state_d = DONE;
      end
      DONE: begin
        _done = 1'b1;
      end
      default: ;
    endcase

    // Write side of the skid FIFO, shared by DRAW and DRAIN.
    if ((state_q == DRAW || state_q == DRAIN) && !fifo_empty) begin
      fifo_pop  = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ADDR_W'(head_entry.addr);
      mem_data  = color_q;
      pix_cnt_d = sat_inc(pix_cnt_q);
`ifdef PIXEL_PLOTTER_BBOX_EN
      if (head_entry.x < xmin_q) xmin_d = head_entry.x;
      if (head_entry.x > xmax_q) xmax_d = head_entry.x;
      if (head_entry.y < ymin_q) ymin_d = head_entry.y;
      if (head_entry.y > ymax_q) ymax_d = head_entry.y;
`endif
    end

    // A start aborts whatever is in flight, including a pixel popping this cycle.
    if (_start) begin
      state_d    = CLEAR;
      clr_d      = '0;
      color_d    = color;
      bg_d       = bg_color;
      pix_cnt_d  = '0;
      clip_cnt_d = '0;
      fifo_clear = 1'b1;
      fifo_push  = 1'b0;
      if (fifo_pop) begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
      end
      fifo_pop   = 1'b0;
`ifdef PIXEL_PLOTTER_BBOX_EN
      xmin_d     = 32'sh7FFF_FFFF;
      xmax_d     = 32'sh8000_0000;
      ymin_d     = 32'sh7FFF_FFFF;
      ymax_d     = 32'sh8000_0000;
`endif
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q    <= IDLE;
      clr_q      <= '0;
      color_q    <= '0;
      bg_q       <= '0;
      pix_cnt_q  <= '0;
      clip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      color_q    <= color_d;
      bg_q       <= bg_d;
      pix_cnt_q  <= pix_cnt_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

`ifdef PIXEL_PLOTTER_BBOX_EN
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      xmin_q <= 32'sh7FFF_FFFF;
      xmax_q <= 32'sh8000_0000;
      ymin_q <= 32'sh7FFF_FFFF;
      ymax_q <= 32'sh8000_0000;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end
`endif

  assign pixel_count = pix_cnt_q;
  assign clip_count  = clip_cnt_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// Directed bench for pixel_plotter: a 4x2 instance for the clear pass and a 16x8 instance for drawing,
// plus a standalone plotter_fifo instance to exercise fill and push-while-full.
module tb_pixel_plotter;

  localparam int AW = 12;
  localparam int CW = 8;
  localparam int BW = 16;
  localparam int BH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [CW-1:0] color = '0, bg_color = '0;
  logic in_valid = 1'b0, in_done = 1'b0;
  logic signed [31:0] in0 = '0, in1 = '0;

  logic a_ready, a_we, a_done;
  logic [AW-1:0] a_addr;
  logic [CW-1:0] a_data;
  logic [31:0] a_pix, a_clip;
  logic b_ready, b_we, b_done;
  logic [AW-1:0] b_addr;
  logic [CW-1:0] b_data;
  logic [31:0] b_pix, b_clip;

  logic f_clear = 1'b0, f_push = 1'b0, f_pop = 1'b0;
  logic [7:0] f_wdata = '0, f_rdata;
  logic f_full, f_empty;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pixel_plotter #(.FB_WIDTH(4), .FB_HEIGHT(2)) dut_a (
    ._clock(clk), ._reset_n(rst_n), ._start(start_a), .color(color), .bg_color(bg_color),
    ._in_valid(in_valid), ._in0(in0), ._in1(in1), ._in_done(in_done), ._in_ready(a_ready),
    .mem_we(a_we), .mem_addr(a_addr), .mem_data(a_data), .pixel_count(a_pix),
    .clip_count(a_clip), ._done(a_done)
  );

  pixel_plotter #(.FB_WIDTH(BW), .FB_HEIGHT(BH)) dut_b (
    ._clock(clk), ._reset_n(rst_n), ._start(start_b), .color(color), .bg_color(bg_color),
    ._in_valid(in_valid), ._in0(in0), ._in1(in1), ._in_done(in_done), ._in_ready(b_ready),
    .mem_we(b_we), .mem_addr(b_addr), .mem_data(b_data), .pixel_count(b_pix),
    .clip_count(b_clip), ._done(b_done)
  );

  plotter_fifo #(.DEPTH(4), .WIDTH(8)) u_fifo (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(f_clear), .push_i(f_push), .wdata_i(f_wdata),
    .pop_i(f_pop), .rdata_o(f_rdata), .full_o(f_full), .empty_o(f_empty)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse start on dut_b and wait (bounded) for the first DRAW cycle.
  task automatic start_frame_b(input logic [CW-1:0] c, input logic [CW-1:0] bg, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    start_b = 1'b1; color = c; bg_color = bg;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (b_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Raise in_done on dut_b and wait (bounded) for done.
  task automatic finish_frame_b(output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_done = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (b_done) begin ok = 1'b1; break; end
    end
    in_done = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (b_we !== 1'b0 || b_addr !== '0 || b_data !== '0 || b_ready !== 1'b0 ||
        b_pix !== 32'd0 || b_clip !== 32'd0 || b_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: we=%b addr=%0d data=%h ready=%b pix=%0d clip=%0d done=%b, required all zero",
               b_we, b_addr, b_data, b_ready, b_pix, b_clip, b_done);
    end
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_clear;
    @(negedge clk);
    start_a = 1'b1; bg_color = 8'h11; color = 8'h22;
    #1;
    total++;
    if (a_we !== 1'b0) begin bad++; $display("FAIL clear_idle_we: got %b required 0", a_we); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      #1;
      total++;
      if (a_we !== 1'b1 || a_addr !== AW'(i) || a_data !== 8'h11) begin
        bad++;
        $display("FAIL clear_write%0d: we=%b addr=%0d data=%h required we=1 addr=%0d data=11",
                 i, a_we, a_addr, a_data, i);
      end
      $display("txn clear write addr=%0d data=%h", a_addr, a_data);
    end
    @(negedge clk);
    #1;
    total++;
    if (a_we !== 1'b0 || a_ready !== 1'b1) begin
      bad++;
      $display("FAIL clear_end: we=%b ready=%b required we=0 ready=1", a_we, a_ready);
    end
  endtask

  task automatic test_rectangle;
    bit ok;
    int exp_addr [6] = '{17, 18, 19, 33, 34, 35};
    start_frame_b(8'hAA, 8'h00, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rect_start: in_ready never rose, required 1"); end
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      in_valid = (i < 6);
      in0 = 32'(1 + (i % 3));
      in1 = 32'(1 + (i / 3));
      #1;
      total++;
      if (i == 0) begin
        if (b_we !== 1'b0) begin bad++; $display("FAIL rect_first_idle: we=%b required 0", b_we); end
      end else if (b_we !== 1'b1 || b_addr !== AW'(exp_addr[i-1]) || b_data !== 8'hAA) begin
        bad++;
        $display("FAIL rect_write%0d: we=%b addr=%0d data=%h required we=1 addr=%0d data=aa",
                 i - 1, b_we, b_addr, b_data, exp_addr[i-1]);
      end
      if (b_we) $display("txn rect write addr=%0d data=%h", b_addr, b_data);
    end
    finish_frame_b(ok);
    total++;
    if (!ok || b_pix !== 32'd6 || b_clip !== 32'd0) begin
      bad++;
      $display("FAIL rect_done: done=%b pix=%0d clip=%0d required done=1 pix=6 clip=0", ok, b_pix, b_clip);
    end
  endtask

  task automatic test_clipping;
    bit ok;
    int xs [4] = '{-1, BW, 0, 2};
    int ys [4] = '{0, 0, BH, 1};
    start_frame_b(8'h5A, 8'h00, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL clip_start: in_ready never rose, required 1"); end
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      in_valid = (i < 4);
      if (i < 4) begin in0 = 32'(xs[i]); in1 = 32'(ys[i]); end
      #1;
      total++;
      if (i < 4 && b_we !== 1'b0) begin
        bad++; $display("FAIL clip_nowrite%0d: we=%b required 0", i, b_we);
      end else if (i == 4 && (b_we !== 1'b1 || b_addr !== AW'(BW + 2) || b_data !== 8'h5A)) begin
        bad++;
        $display("FAIL clip_write: we=%b addr=%0d data=%h required we=1 addr=%0d data=5a",
                 b_we, b_addr, b_data, BW + 2);
      end
      if (i == 3) begin
        total++;
        if (b_clip !== 32'd3) begin bad++; $display("FAIL clip_count_mid: got %0d required 3", b_clip); end
      end
      if (b_we) $display("txn clip write addr=%0d data=%h", b_addr, b_data);
    end
    finish_frame_b(ok);
    total++;
    if (!ok || b_pix !== 32'd1 || b_clip !== 32'd3) begin
      bad++;
      $display("FAIL clip_done: done=%b pix=%0d clip=%0d required done=1 pix=1 clip=3", ok, b_pix, b_clip);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    start_frame_b(8'h33, 8'h00, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_start: in_ready never rose, required 1"); end
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      in_valid = (i < 3);
      in0 = 32'sd3; in1 = 32'sd3;
      #1;
      total++;
      if (i < 3 && b_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready%0d: got %b required 1", i, b_ready);
      end else if (i >= 1 && i <= 3 && (b_we !== 1'b1 || b_addr !== AW'(3 * BW + 3))) begin
        bad++;
        $display("FAIL b2b_write%0d: we=%b addr=%0d required we=1 addr=%0d", i, b_we, b_addr, 3 * BW + 3);
      end else if ((i == 0 || i == 4) && b_we !== 1'b0) begin
        bad++; $display("FAIL b2b_idle%0d: we=%b required 0", i, b_we);
      end
      if (b_we) $display("txn b2b write addr=%0d data=%h", b_addr, b_data);
    end
    finish_frame_b(ok);
    total++;
    if (!ok || b_pix !== 32'd3) begin
      bad++; $display("FAIL b2b_done: done=%b pix=%0d required done=1 pix=3", ok, b_pix);
    end
  endtask

  task automatic test_fifo_full;
    logic [7:0] exp_out [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA5};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      f_push = 1'b1; f_wdata = 8'(8'hA0 + i);
    end
    @(negedge clk);
    f_wdata = 8'hA4;
    #1;
    total++;
    if (f_full !== 1'b1 || f_empty !== 1'b0 || f_rdata !== 8'hA0) begin
      bad++; $display("FAIL fifo_full: full=%b empty=%b head=%h required 1 0 a0", f_full, f_empty, f_rdata);
    end
    @(negedge clk);
    f_wdata = 8'hA5; f_pop = 1'b1;
    #1;
    total++;
    if (f_rdata !== 8'hA0 || f_full !== 1'b1) begin
      bad++; $display("FAIL fifo_push_when_full: head=%h full=%b required a0 1", f_rdata, f_full);
    end
    @(negedge clk);
    f_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (f_rdata !== exp_out[i] || f_empty !== 1'b0) begin
        bad++; $display("FAIL fifo_pop%0d: head=%h empty=%b required %h 0", i, f_rdata, f_empty, exp_out[i]);
      end
      @(negedge clk);
    end
    f_pop = 1'b0;
    #1;
    total++;
    if (f_empty !== 1'b1) begin bad++; $display("FAIL fifo_empty: got %b required 1", f_empty); end
  endtask

  task automatic test_abort;
    bit ok;
    int errs;
    start_frame_b(8'h77, 8'h00, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL abort_start: in_ready never rose, required 1"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in0 = 32'(i); in1 = 32'sd0;
      #1;
      if (i > 0) begin
        total++;
        if (b_we !== 1'b1 || b_addr !== AW'(i - 1)) begin
          bad++; $display("FAIL abort_write%0d: we=%b addr=%0d required we=1 addr=%0d", i - 1, b_we, b_addr, i - 1);
        end
      end
    end
    @(negedge clk);
    in0 = 32'sd3; start_b = 1'b1; bg_color = 8'h55; color = 8'h66;
    #1;
    total++;
    if (b_we !== 1'b0) begin bad++; $display("FAIL abort_gate: we=%b required 0", b_we); end
    @(negedge clk);
    start_b = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (b_we !== 1'b1 || b_addr !== '0 || b_data !== 8'h55 || b_pix !== 32'd0 || b_clip !== 32'd0) begin
      bad++;
      $display("FAIL abort_restart: we=%b addr=%0d data=%h pix=%0d clip=%0d required 1 0 55 0 0",
               b_we, b_addr, b_data, b_pix, b_clip);
    end
    errs = 0;
    for (int k = 1; k < BW * BH; k++) begin
      @(negedge clk);
      #1;
      if (b_we !== 1'b1 || b_addr !== AW'(k) || b_data !== 8'h55) errs++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (b_we !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL abort_clear_pass: %0d bad cycles required 0", errs); end
    finish_frame_b(ok);
    total++;
    if (!ok || b_pix !== 32'd0) begin
      bad++; $display("FAIL abort_done: done=%b pix=%0d required done=1 pix=0", ok, b_pix);
    end
  endtask

  task automatic test_async_reset;
    int errs;
    @(negedge clk);
    start_b = 1'b1; bg_color = 8'h44;
    @(negedge clk);
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (b_we !== 1'b1) begin bad++; $display("FAIL areset_pre: we=%b required 1", b_we); end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (b_we !== 1'b0 || b_done !== 1'b0 || b_ready !== 1'b0 || b_addr !== '0) begin
      bad++;
      $display("FAIL areset_now: we=%b done=%b ready=%b addr=%0d required 0 0 0 0", b_we, b_done, b_ready, b_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (b_we !== 1'b0 || b_ready !== 1'b0 || b_done !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL areset_idle: %0d active cycles required 0", errs); end
    @(negedge clk);
    start_b = 1'b1; bg_color = 8'h99;
    @(negedge clk);
    start_b = 1'b0;
    #1;
    total++;
    if (b_we !== 1'b1 || b_addr !== '0 || b_data !== 8'h99) begin
      bad++; $display("FAIL areset_restart: we=%b addr=%0d data=%h required 1 0 99", b_we, b_addr, b_data);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_rectangle();
    test_clipping();
    test_back_to_back();
    test_fifo_full();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
